xalu_core: RTL

Parametrised, registered successor to the team's 4-bit combinational ALU slice: a WIDTH-bit ALU with registered results and status flags, a start/busy/done handshake, and multi-cycle rotate and optional multiply. It sits behind the Tiny Tapeout top wrapper, which maps pins onto its operand, opcode and flag ports. Single-cycle ops complete in one clock; iterative ops run bit-serially to save area.

---
 rtl/xalu_core.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/xalu_core.sv
// xalu_core: registered WIDTH-bit ALU with start/busy/done handshake, bit-serial
// rotate and, when XALU_MUL_EN is defined, a shift-add multiplier (opcode 11).
module xalu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             com,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             co,
  output logic             zero,
  output logic             neg_zero,
  output logic             equ,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2, OP_XOR = 4'd3,
                         OP_PSA = 4'd4, OP_PSB = 4'd5, OP_SHR = 4'd6, OP_SHL = 4'd7,
                         OP_SUB = 4'd8, OP_ROR = 4'd9, OP_ROL = 4'd10, OP_MUL = 4'd11;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      cnt, amt;
  logic [3:0]         op_q;
  logic               com_q, equ_q;
  logic [2*WIDTH-1:0] wrk, wrk_nx;
  logic               step_co, is_rot, is_mul, legal;
  logic [WIDTH-1:0]   sc_y, fin_y, fin_hi;
  logic               sc_co, load, fin, fin_ill, fin_co, fin_equ, fin_com;

  assign amt    = CW'(b % WIDTH);
  assign is_rot = (op == OP_ROR) || (op == OP_ROL);
  assign busy   = (state == RUN);

`ifdef XALU_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   psum;
  assign is_mul = (op == OP_MUL);
`else
  assign is_mul = 1'b0;
  assign y_hi   = '0;
`endif

  // single-cycle datapath, also covers rotate by zero
  always_comb begin
    sc_y  = a;
    sc_co = 1'b0;
    legal = 1'b1;
    case (op)
      OP_ADD:         {sc_co, sc_y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      OP_AND:         sc_y = a & b;
      OP_OR:          sc_y = a | b;
      OP_XOR:         sc_y = a ^ b;
      OP_PSA:         sc_y = a;
      OP_PSB:         sc_y = b;
      OP_SHR:         begin sc_y = {ci, a[WIDTH-1:1]}; sc_co = a[0]; end
      OP_SHL:         begin sc_y = {a[WIDTH-2:0], ci}; sc_co = a[WIDTH-1]; end
      OP_SUB:         {sc_co, sc_y} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      OP_ROR, OP_ROL: sc_y = a;
      OP_MUL:         legal = is_mul;
      default:        legal = 1'b0;
    endcase
  end

  // one iterative step; rotates live in the low half of wrk, MUL uses all of it
  always_comb begin
    wrk_nx  = wrk;
    step_co = 1'b0;
`ifdef XALU_MUL_EN
    psum = {1'b0, wrk[2*WIDTH-1:WIDTH]} + (wrk[0] ? {1'b0, mcand} : '0);
`endif
    case (op_q)
      OP_ROR: begin wrk_nx[WIDTH-1:0] = {wrk[0], wrk[WIDTH-1:1]}; step_co = wrk[0]; end
      OP_ROL: begin wrk_nx[WIDTH-1:0] = {wrk[WIDTH-2:0], wrk[WIDTH-1]}; step_co = wrk[WIDTH-1]; end
`ifdef XALU_MUL_EN
      OP_MUL: wrk_nx = {psum, wrk[WIDTH-1:1]};
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    fin      = 1'b0;
    fin_ill  = 1'b0;
    fin_y    = sc_y;
    fin_hi   = '0;
    fin_co   = sc_co;
    fin_equ  = (a == b);
    fin_com  = com;
    case (state)
      IDLE: if (start) begin
        if (!legal) begin
          fin     = 1'b1;
          fin_ill = 1'b1;
        end else if (is_mul || (is_rot && amt != '0)) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          fin = 1'b1;
        end
      end
      RUN: if (cnt == CW'(1)) begin
        state_nx = IDLE;
        fin      = 1'b1;
        fin_y    = wrk_nx[WIDTH-1:0];
        fin_co   = step_co;
        fin_equ  = equ_q;
        fin_com  = com_q;
`ifdef XALU_MUL_EN
        if (op_q == OP_MUL) fin_hi = com_q ? ~wrk_nx[2*WIDTH-1:WIDTH] : wrk_nx[2*WIDTH-1:WIDTH];
`endif
      end
      default: state_nx = IDLE;
    endcase
    if (fin_com) fin_y = ~fin_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      com_q    <= 1'b0;
      equ_q    <= 1'b0;
      wrk      <= '0;
      done     <= 1'b0;
      y        <= '0;
      co       <= 1'b0;
      zero     <= 1'b0;
      neg_zero <= 1'b0;
      equ      <= 1'b0;
      err      <= 1'b0;
    end else if (ena) begin
      state <= state_nx;
      done  <= fin;
      if (load) begin
        op_q  <= op;
        com_q <= com;
        equ_q <= (a == b);
        wrk   <= {{WIDTH{1'b0}}, a};
        cnt   <= is_mul ? CW'(WIDTH) : amt;
      end else if (state == RUN) begin
        wrk <= wrk_nx;
        cnt <= cnt - 1'b1;
      end
      // illegal ops report err but leave the previous result visible
      if (fin) begin
        err <= fin_ill;
        if (!fin_ill) begin
          y        <= fin_y;
          co       <= fin_co;
          zero     <= ~|{fin_hi, fin_y};
          neg_zero <= &{fin_hi, fin_y};
          equ      <= fin_equ;
        end
      end
    end
  end

`ifdef XALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      y_hi  <= '0;
    end else if (ena) begin
      if (load) mcand <= b;
      if (fin && !fin_ill) y_hi <= fin_hi;
    end
  end
`endif

endmodule
